// File: rtl/delay_wakeup_mc.sv
// Multi-channel delay/wakeup timer: per-channel one-shot or periodic wake pulses.
// Define DWK_RETRIGGER_EN to let start restart a channel that is already counting.
module delay_wakeup_mc #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   start,
  input  logic [CH*W-1:0] wdy,
  input  logic [CH-1:0]   mode,
  input  logic [CH-1:0]   abort,
  output logic [CH-1:0]   valid,
  output logic [CH-1:0]   busy,
  output logic            any_valid
);

  typedef enum logic {StIdle, StCount} state_e;

  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] reload_q, reload_d;
    logic         per_q, per_d;
    logic         valid_q, valid_d;
    logic [W-1:0] d;

    assign d = wdy[i*W +: W];

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      per_d    = per_q;
      valid_d  = 1'b0;
      if (abort[i]) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start[i]) begin
              if (d == '0) begin
                // Zero delay fires immediately, even in periodic mode
                valid_d = 1'b1;
              end else begin
                cnt_d    = d - One;
                reload_d = d;
                per_d    = mode[i];
                state_d  = StCount;
              end
            end
          end
          StCount: begin
`ifdef DWK_RETRIGGER_EN
            if (start[i]) begin
              // Restart beats a pulse due on this same edge
              if (d == '0) begin
                valid_d = 1'b1;
                state_d = StIdle;
              end else begin
                cnt_d    = d - One;
                reload_d = d;
                per_d    = mode[i];
              end
            end else
`endif
            if (cnt_q != '0) begin
              cnt_d = cnt_q - One;
            end else begin
              valid_d = 1'b1;
              if (per_q) begin
                cnt_d = reload_q - One;
              end else begin
                state_d = StIdle;
              end
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        reload_q <= '0;
        per_q    <= 1'b0;
        valid_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        reload_q <= reload_d;
        per_q    <= per_d;
        valid_q  <= valid_d;
      end
    end

    assign valid[i] = valid_q;
    assign busy[i]  = (state_q == StCount);
  end

  assign any_valid = |valid;

endmodule

// File: doc/delay_wakeup_mc.md
# delay_wakeup_mc

Multi-channel, parametrised successor to the single-channel delay/wakeup timer. Each of CH independent channels is armed by a start strobe. After a programmable number of clock cycles the channel emits a one-cycle `valid` wake pulse, either once (one-shot) or repeatedly (periodic). The block sits between control logic that schedules wakeups and the blocks being woken. A combined `any_valid` output is provided for a shared interrupt or wake line.

## Interface
Parameters:
- CH, 4, number of independent channels (≥1)
- W, 8, delay width in bits; maximum delay 2^W−1 cycles

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  CH  per-channel arm strobe, sampled each edge
- wdy  input  CH*W  per-channel delay; channel i uses bits [i*W +: W], sampled only when start[i]=1
- mode  input  CH  per-channel mode, sampled with start: 0 = one-shot, 1 = periodic
- abort  input  CH  per-channel cancel
- valid  output  CH  per-channel wake pulse, registered, one cycle wide
- busy  output  CH  channel is counting (state COUNT)
- any_valid  output  1  OR of valid[CH-1:0]

## Operation
- Per-channel FSM, two states: IDLE and COUNT. Per-channel registers:
  - cnt [W-1:0]
  - reload [W-1:0]
  - per [1]
- Priority per channel, per edge: reset > abort > start > count.
- IDLE:
  - start=1, wdy=0: set valid=1 for one cycle and stay IDLE. Periodic mode with wdy=0 is treated as one-shot.
  - start=1, wdy≠0: set cnt=wdy−1, reload=wdy, per=mode, and go to COUNT.
- COUNT:
  - cnt≠0: cnt=cnt−1.
  - cnt=0 and per=1: set valid=1, cnt=reload−1, stay in COUNT.
  - cnt=0 and per=0: set valid=1, go to IDLE.
- abort=1: go to IDLE, valid=0 on that edge. Any pending pulse is dropped.
- start=1 while in COUNT (retrigger): behaviour is set by the macro (see Configuration).
- Channels are fully independent. Any combination may fire on the same cycle.
- busy[i] = (state_i == COUNT).
- any_valid is combinational OR of the registered valid bits.
- Arithmetic: unsigned W-bit. The counter never wraps, because it is only decremented when non-zero.

## Timing
- Let E0 be the edge where start is sampled with delay D=wdy.
- valid is high for exactly the one cycle following edge E_D. D=0 means the cycle after E0.
- busy is high after E0 through E_(D−1), and low after E_D in one-shot mode.
- Periodic mode: valid pulses follow E_D, E_2D, E_3D, … until abort or reset. busy stays high throughout.
- Retrigger on the same edge that would fire: the restart wins, no valid on that edge, and the new delay counts from that edge.
- Reset: on any edge with rst=0, for all channels:
  - state=IDLE
  - valid=0, busy=0, any_valid=0
  - cnt=0, reload=0, per=0
- Reset applied mid-count: the pulse is lost, and no pulse is emitted after rst returns high.
- Reset has no combinational path to outputs. Outputs change only on edges.

## Configuration
- DWK_RETRIGGER_EN defined: start in COUNT reloads cnt=wdy−1, reload=wdy and per=mode. If wdy=0, valid is emitted on that edge and the channel goes to IDLE.
- DWK_RETRIGGER_EN undefined: start is ignored while in COUNT. The channel completes its current delay, and abort remains effective.

## Test plan
- Reset: hold rst=0 for 3 edges with start=4'hF and wdy all 8'd2. Required: valid=0, busy=0 and any_valid=0 throughout, and no pulse after release.
- One-shot: ch0 start, wdy=8'd5, mode=0. Required: valid[0] high for one cycle after E5 only; busy[0] high for 5 cycles; other channels quiet.
- Periodic and abort: ch1 wdy=8'd3, mode=1. Required: valid[1] pulses after E3 and E6. With abort[1] at E7, no pulse after E9, and busy[1]=0 after E7.
- Zero delay: ch2 start, wdy=0, mode=1. Required: valid[2] pulses once after E0, and busy[2] never rises.
- Retrigger: ch2 wdy=8'd10 at E0, then start again at E4 with wdy=8'd10. Required with DWK_RETRIGGER_EN: single valid[2] after E14. Required without the macro: single valid[2] after E10.
- Concurrency and reset mid-count: ch0 and ch3 both with wdy=8'd4 at E0. Required: valid=4'b1001 and any_valid=1 for the one cycle after E4. Then re-arm both and pull rst=0 at E2. Required: no valid on either channel.
